// File: rtl/noc_pkg.sv
// Shared mesh-router constants: port indices, default field widths and the
// input-port FSM encoding.
package noc_pkg;

    localparam int RESOURCE = 0;
    localparam int WEST     = 1;
    localparam int EAST     = 2;
    localparam int NORTH    = 3;
    localparam int SOUTH    = 4;
    localparam int OUTPUTS  = 5;

    localparam int OUTPUT_N_W      = 3;
    localparam int PACKET_ADDR_X_W = 4;
    localparam int PACKET_ADDR_Y_W = 4;
    localparam int PAYLOAD_W       = 8;
    localparam int FLIT_W          = PAYLOAD_W + PACKET_ADDR_Y_W + PACKET_ADDR_X_W;

    // Flit layout {y_addr, x_addr, payload}, payload at the LSBs.
    localparam int PAYLOAD_LSB = 0;
    localparam int X_LSB       = PAYLOAD_W;
    localparam int Y_LSB       = PAYLOAD_W + PACKET_ADDR_X_W;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } port_state_e;

endpackage

// File: rtl/xy_input_port_if.sv
// Upstream flit handshake, router lookup and arbiter request bundle of one
// router input port.
interface xy_input_port_if #(
    parameter int PACKET_ADDR_X_W = noc_pkg::PACKET_ADDR_X_W,
    parameter int PACKET_ADDR_Y_W = noc_pkg::PACKET_ADDR_Y_W,
    parameter int FLIT_W          = noc_pkg::FLIT_W,
    parameter int OUTPUT_N_W      = noc_pkg::OUTPUT_N_W,
    parameter int OUTPUTS         = noc_pkg::OUTPUTS
);
    logic [FLIT_W-1:0]          data_i;
    logic                       valid_i;
    logic                       ready_o;
    logic [PACKET_ADDR_X_W-1:0] x_addr_o;
    logic [PACKET_ADDR_Y_W-1:0] y_addr_o;
    logic [OUTPUT_N_W-1:0]      route_sel_i;
    logic [OUTPUTS-1:0]         req_o;
    logic                       grant_i;
    logic [FLIT_W-1:0]          data_o;
    logic                       route_err_o;

    modport slave (
        input  data_i, valid_i, route_sel_i, grant_i,
        output ready_o, x_addr_o, y_addr_o, req_o, data_o, route_err_o
    );

    modport master (
        output data_i, valid_i, route_sel_i, grant_i,
        input  ready_o, x_addr_o, y_addr_o, req_o, data_o, route_err_o
    );
endinterface

// File: rtl/flit_fifo.sv
// Synchronous flit FIFO with registered occupancy count; head is the
// entry at the read pointer.
module flit_fifo #(
    parameter int FLIT_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [FLIT_W-1:0] data_i,
    input  logic              pop_i,
    output logic [FLIT_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [FLIT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic              do_push, do_pop;

    assign full_o  = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty_o = (count == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem[rd_ptr];

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + (PTR_W+1)'(1);
            else if (do_pop && !do_push) count <= count - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/xy_input_port.sv
// Router input port: buffers flits, latches the xy_router decision, requests
// the routed output and pops on grant; illegal routes are dropped with a pulse.
module xy_input_port #(
    parameter int PACKET_ADDR_X_W = noc_pkg::PACKET_ADDR_X_W,
    parameter int PACKET_ADDR_Y_W = noc_pkg::PACKET_ADDR_Y_W,
    parameter int PAYLOAD_W       = noc_pkg::PAYLOAD_W,
    parameter int FLIT_W          = PAYLOAD_W + PACKET_ADDR_Y_W + PACKET_ADDR_X_W,
    parameter int FIFO_DEPTH      = 4,
    parameter int OUTPUT_N_W      = noc_pkg::OUTPUT_N_W,
    parameter int OUTPUTS         = noc_pkg::OUTPUTS
) (
    input logic          clk_i,
    input logic          rst_ni,
    xy_input_port_if.slave port
);
    import noc_pkg::*;

    localparam int X_OFS = PAYLOAD_W;
    localparam int Y_OFS = PAYLOAD_W + PACKET_ADDR_X_W;

    port_state_e           state_q, state_d;
    logic [OUTPUT_N_W-1:0] route_q, route_d;
    logic [FLIT_W-1:0]     head;
    logic                  full, empty, push, pop, drop, err_q, init_q, sel_ok;

    // init_q keeps ready_o low until the first edge after reset release.
    assign port.ready_o     = init_q && !full;
    assign push             = port.valid_i && port.ready_o;
    assign port.data_o      = empty ? '0 : head;
    assign port.x_addr_o    = port.data_o[X_OFS +: PACKET_ADDR_X_W];
    assign port.y_addr_o    = port.data_o[Y_OFS +: PACKET_ADDR_Y_W];
    assign port.req_o       = (state_q == REQ) ? (OUTPUTS'(1) << route_q) : '0;
    assign port.route_err_o = err_q;
    assign sel_ok           = (port.route_sel_i < OUTPUT_N_W'(OUTPUTS));

    flit_fifo #(
        .FLIT_W     (FLIT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (port.data_i),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d = state_q;
        route_d = route_q;
        pop     = 1'b0;
        drop    = 1'b0;
        if (state_q == IDLE) begin
            if (!empty) begin
                if (sel_ok) begin
                    route_d = port.route_sel_i;
                    state_d = REQ;
                end else begin
                    drop = 1'b1;
                    pop  = 1'b1;
                end
            end
        end else if (port.grant_i) begin
            pop     = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            route_q <= '0;
            err_q   <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
            err_q   <= drop;
            init_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_xy_input_port.sv
// Scoreboard bench for xy_input_port at router coordinate (1,1); directed
// flits queue their expected crossbar flit and request, a monitor checks pops.
module tb_xy_input_port;
    import noc_pkg::*;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    xy_input_port_if #(
        .PACKET_ADDR_X_W(4), .PACKET_ADDR_Y_W(4), .FLIT_W(16),
        .OUTPUT_N_W(3), .OUTPUTS(5)
    ) bus ();

    xy_input_port #(
        .PACKET_ADDR_X_W(4), .PACKET_ADDR_Y_W(4), .PAYLOAD_W(8), .FLIT_W(16),
        .FIFO_DEPTH(4), .OUTPUT_N_W(3), .OUTPUTS(5)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .port   (bus)
    );

    typedef struct {
        logic [15:0] flit;
        logic [4:0]  req;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   err_pulses = 0;
    logic force_bad = 1'b0;

    // xy_router stand-in at X_CORD=1, Y_CORD=1.
    always_comb begin
        bus.route_sel_i = 3'(RESOURCE);
        if (force_bad)               bus.route_sel_i = 3'd6;
        else if (bus.x_addr_o > 4'd1) bus.route_sel_i = 3'(EAST);
        else if (bus.x_addr_o < 4'd1) bus.route_sel_i = 3'(WEST);
        else if (bus.y_addr_o > 4'd1) bus.route_sel_i = 3'(NORTH);
        else if (bus.y_addr_o < 4'd1) bus.route_sel_i = 3'(SOUTH);
    end

    function automatic logic [15:0] mk(input logic [3:0] x, input logic [3:0] y,
                                       input logic [7:0] p);
        return {y, x, p};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out, expected DUT event", name);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [15:0] flit, input logic [4:0] req, input bit expect_out);
        bit acc = 1'b0;
        bus.data_i  = flit;
        bus.valid_i = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk_i);
            if (bus.ready_o) begin
                acc = 1'b1;
                if (expect_out) exp_q.push_back('{flit: flit, req: req});
            end
            @(posedge clk_i);
            #1;
        end
        bus.valid_i = 1'b0;
        if (!acc) fail_timeout("send");
    endtask

    task automatic wait_req();
        for (int i = 0; i < 30 && bus.req_o == '0; i++) tick();
        if (bus.req_o == '0) fail_timeout("wait_req");
    endtask

    task automatic grant_one();
        wait_req();
        bus.grant_i = 1'b1;
        tick();
        bus.grant_i = 1'b0;
    endtask

    // Every granted request must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (rst_ni && bus.grant_i && bus.req_o != '0) begin
            if (exp_q.size() == 0) begin
                fail_timeout("unexpected_pop");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pop_data", 32'(bus.data_o), 32'(e.flit));
                chk("pop_req", 32'(bus.req_o), 32'(e.req));
            end
        end
        if (bus.route_err_o) err_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit saw_req;
        bus.data_i  = '0;
        bus.valid_i = 1'b0;
        bus.grant_i = 1'b0;

        // Reset and idle
        #12;
        chk("rst_ready", 32'(bus.ready_o), 0);
        chk("rst_req", 32'(bus.req_o), 0);
        chk("rst_err", 32'(bus.route_err_o), 0);
        #5 rst_ni = 1'b1;
        #1 chk("ready_before_edge", 32'(bus.ready_o), 0);
        tick();
        chk("ready_after_edge", 32'(bus.ready_o), 1);
        chk("idle_x", 32'(bus.x_addr_o), 0);
        chk("idle_y", 32'(bus.y_addr_o), 0);
        chk("idle_data", 32'(bus.data_o), 0);
        tick();
        tick();
        chk("idle_req", 32'(bus.req_o), 0);

        // Single flit x=3 y=1 payload A5, EAST
        send(mk(4'd3, 4'd1, 8'hA5), 5'b00100, 1'b1);
        chk("c1_x", 32'(bus.x_addr_o), 3);
        chk("c1_y", 32'(bus.y_addr_o), 1);
        chk("c1_req", 32'(bus.req_o), 0);
        tick();
        chk("c2_req", 32'(bus.req_o), 32'b00100);
        tick();
        chk("c3_req_hold", 32'(bus.req_o), 32'b00100);
        tick();
        bus.grant_i = 1'b1;
        #1 chk("c4_data", 32'(bus.data_o), 32'h13A5);
        tick();
        bus.grant_i = 1'b0;
        chk("c5_req", 32'(bus.req_o), 0);
        chk("c5_empty_data", 32'(bus.data_o), 0);

        // Fill to full without grants, then drain in order
        send(mk(4'd1, 4'd1, 8'h11), 5'b00001, 1'b1);
        send(mk(4'd0, 4'd1, 8'h22), 5'b00010, 1'b1);
        send(mk(4'd1, 4'd3, 8'h33), 5'b01000, 1'b1);
        send(mk(4'd1, 4'd0, 8'h44), 5'b10000, 1'b1);
        chk("full_ready", 32'(bus.ready_o), 0);
        grant_one();
        chk("ready_after_pop", 32'(bus.ready_o), 1);
        grant_one();
        grant_one();
        grant_one();
        tick();
        chk("drained_data", 32'(bus.data_o), 0);

        // Simultaneous push and pop at count 2
        send(mk(4'd2, 4'd1, 8'h51), 5'b00100, 1'b1);
        send(mk(4'd1, 4'd2, 8'h52), 5'b01000, 1'b1);
        wait_req();
        bus.data_i  = mk(4'd0, 4'd0, 8'h53);
        bus.valid_i = 1'b1;
        bus.grant_i = 1'b1;
        @(negedge clk_i);
        chk("simul_ready", 32'(bus.ready_o), 1);
        exp_q.push_back('{flit: mk(4'd0, 4'd0, 8'h53), req: 5'b00010});
        tick();
        bus.valid_i = 1'b0;
        bus.grant_i = 1'b0;
        send(mk(4'd1, 4'd1, 8'h54), 5'b00001, 1'b1);
        chk("count3_ready", 32'(bus.ready_o), 1);
        send(mk(4'd3, 4'd3, 8'h55), 5'b00100, 1'b1);
        chk("count4_ready", 32'(bus.ready_o), 0);
        for (int i = 0; i < 4; i++) grant_one();
        tick();
        chk("simul_drained", 32'(exp_q.size()), 0);

        // Illegal route select drops the flit
        force_bad  = 1'b1;
        err_pulses = 0;
        saw_req    = 1'b0;
        send(mk(4'd5, 4'd5, 8'h77), 5'b00000, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (bus.req_o != '0) saw_req = 1'b1;
            tick();
        end
        force_bad = 1'b0;
        chk("err_pulses", 32'(err_pulses), 1);
        chk("err_no_req", 32'(saw_req), 0);
        chk("err_dropped", 32'(bus.data_o), 0);

        // Reset while requesting with three flits queued
        send(mk(4'd3, 4'd1, 8'h61), 5'b00000, 1'b0);
        send(mk(4'd0, 4'd0, 8'h62), 5'b00000, 1'b0);
        send(mk(4'd1, 4'd1, 8'h63), 5'b00000, 1'b0);
        wait_req();
        chk("midreq_req", 32'(bus.req_o), 32'b00100);
        #2 rst_ni = 1'b0;
        #1 chk("async_req", 32'(bus.req_o), 0);
        chk("async_ready", 32'(bus.ready_o), 0);
        @(posedge clk_i);
        #2 rst_ni = 1'b1;
        #1 chk("post_rst_ready0", 32'(bus.ready_o), 0);
        chk("post_rst_empty", 32'(bus.data_o), 0);
        chk("post_rst_x", 32'(bus.x_addr_o), 0);
        tick();
        chk("post_rst_ready1", 32'(bus.ready_o), 1);
        tick();
        tick();
        chk("post_rst_req", 32'(bus.req_o), 0);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
